// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program-counter register and instruction-fetch sequencer.
// Supplies PC+1 to the next-PC mux, latches the mux result when the held
// instruction retires, and runs the instruction-memory request/ack handshake.
// A retired HALT_INSTR parks the unit in HALT until the next reset.
module pc_fetch_unit #(
    parameter int              N          = 16,
    parameter logic [N-1:0]    RESET_PC   = 16'h0000,
    parameter logic [N-1:0]    HALT_INSTR = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       MUX_6_out,
    input  logic               stall,
    input  logic               imem_ack,
    input  logic [N-1:0]       imem_data,
    output logic               imem_req,
    output logic [N-1:0]       imem_addr,
    output logic [N-1:0]       PC,
    output logic [N-1:0]       PC_plus_one,
    output logic [N-1:0]       IR,
    output logic               ir_valid,
    output logic               halted
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_VALID = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t         state_r;
    logic [N-1:0]   pc_r;
    logic [N-1:0]   ir_r;
    logic           req_r;
    logic           ir_valid_r;
    logic           halted_r;
    logic [N-1:0]   pc_plus_one_s;

    // Sequencer: state, PC, IR and all handshake/status outputs, registered together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            ir_r       <= {N{1'b0}};
            req_r      <= 1'b0;
            ir_valid_r <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    // One idle cycle after reset; any ack arriving here is stale.
                    state_r    <= ST_FETCH;
                    req_r      <= 1'b1;
                    ir_valid_r <= 1'b0;
                    halted_r   <= 1'b0;
                end
                ST_FETCH: begin
                    // Request held with a stable address until memory answers.
                    if (imem_ack) begin
                        ir_r       <= imem_data;
                        state_r    <= ST_VALID;
                        req_r      <= 1'b0;
                        ir_valid_r <= 1'b1;
                    end else begin
                        state_r    <= ST_FETCH;
                        req_r      <= 1'b1;
                        ir_valid_r <= 1'b0;
                    end
                end
                ST_VALID: begin
                    // MUX_6_out is only looked at on the retiring edge.
                    if (!stall) begin
                        if (ir_r == HALT_INSTR) begin
                            state_r    <= ST_HALT;
                            req_r      <= 1'b0;
                            ir_valid_r <= 1'b0;
                            halted_r   <= 1'b1;
                        end else begin
                            pc_r       <= MUX_6_out;
                            state_r    <= ST_FETCH;
                            req_r      <= 1'b1;
                            ir_valid_r <= 1'b0;
                        end
                    end else begin
                        state_r    <= ST_VALID;
                        req_r      <= 1'b0;
                        ir_valid_r <= 1'b1;
                    end
                end
                ST_HALT: begin
                    // Terminal until reset.
                    state_r    <= ST_HALT;
                    req_r      <= 1'b0;
                    ir_valid_r <= 1'b0;
                    halted_r   <= 1'b1;
                end
                default: begin
                    state_r    <= ST_BOOT;
                    pc_r       <= RESET_PC;
                    ir_r       <= {N{1'b0}};
                    req_r      <= 1'b0;
                    ir_valid_r <= 1'b0;
                    halted_r   <= 1'b0;
                end
            endcase
        end
    end

    // Incrementer for the next-PC mux; wraps silently at the top of the space.
    always_comb begin
        pc_plus_one_s = pc_r + N'(1);
    end

    assign PC          = pc_r;
    assign PC_plus_one = pc_plus_one_s;
    assign imem_addr   = pc_r;
    assign IR          = ir_r;
    assign imem_req    = req_r;
    assign ir_valid    = ir_valid_r;
    assign halted      = halted_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Testbench for pc_fetch_unit: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level reference model.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] MUX_6_out;
    logic        stall;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] PC;
    logic [15:0] PC_plus_one;
    logic [15:0] IR;
    logic        ir_valid;
    logic        halted;

    int total;
    int bad;

    // Reference model: what the unit is doing, not how it is encoded.
    bit          m_booting;   // first cycle after reset, nothing requested yet
    bit          m_have;      // an unretired instruction is held
    bit          m_halted;    // halt instruction retired
    logic [15:0] m_pc;
    logic [15:0] m_ir;

    pc_fetch_unit #(
        .N          (16),
        .RESET_PC   (16'h0000),
        .HALT_INSTR (16'hFFFF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .MUX_6_out   (MUX_6_out),
        .stall       (stall),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .PC          (PC),
        .PC_plus_one (PC_plus_one),
        .IR          (IR),
        .ir_valid    (ir_valid),
        .halted      (halted)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic        exp_req;
        logic [15:0] exp_pp;
        exp_req = (!m_booting && !m_have && !m_halted);
        exp_pp  = 16'((int'(m_pc) + 1) % 65536);
        check_eq({tag, ".pc"},       PC,                  m_pc);
        check_eq({tag, ".pc1"},      PC_plus_one,         exp_pp);
        check_eq({tag, ".addr"},     imem_addr,           m_pc);
        check_eq({tag, ".ir"},       IR,                  m_ir);
        check_eq({tag, ".ir_valid"}, 16'(ir_valid),       16'(m_have));
        check_eq({tag, ".req"},      16'(imem_req),       16'(exp_req));
        check_eq({tag, ".halted"},   16'(halted),         16'(m_halted));
    endtask

    task automatic model_reset();
        m_booting = 1'b1;
        m_have    = 1'b0;
        m_halted  = 1'b0;
        m_pc      = 16'h0000;
        m_ir      = 16'h0000;
    endtask

    // Assert reset away from a clock edge, check its immediate effect, release
    // #1 after a rising edge.
    task automatic apply_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        check_all({tag, ".held"});
        rst_n = 1'b1;
    endtask

    // One clock: drive inputs, advance the model on the edge, compare.
    task automatic step(input string tag, input logic ack, input logic [15:0] data,
                        input logic stl, input logic [15:0] mux);
        imem_ack  = ack;
        imem_data = data;
        stall     = stl;
        MUX_6_out = mux;
        @(posedge clk);
        if (m_booting) begin
            m_booting = 1'b0;
        end else if (m_halted) begin
            m_halted = 1'b1;
        end else if (!m_have) begin
            if (ack) begin
                m_ir   = data;
                m_have = 1'b1;
            end
        end else if (!stl) begin
            m_have = 1'b0;
            if (m_ir == 16'hFFFF) m_halted = 1'b1;
            else                  m_pc     = mux;
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b1;
        stall     = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        MUX_6_out = 16'h0000;
        model_reset();
        #2;

        // Reset and boot.
        apply_reset("reset");
        check_eq("reset.pc0", PC, 16'h0000);
        check_eq("reset.pc1", PC_plus_one, 16'h0001);
        step("boot", 1'b0, 16'h0000, 1'b0, 16'h0000);
        check_eq("boot.req", 16'(imem_req), 16'h0001);

        // Sequential zero-wait fetch, PC advancing every second cycle.
        for (int i = 0; i < 6; i++)
            step("seq", 1'b1, 16'h1234, 1'b0, m_pc + 16'd1);
        check_eq("seq.pc3", PC, 16'h0003);
        check_eq("seq.ir", IR, 16'h1234);

        // Branch: reach PC=10, then retire to 20.
        step("br_a", 1'b1, 16'h1111, 1'b0, 16'h000A);
        step("br_b", 1'b0, 16'h0000, 1'b0, 16'h000A);
        step("br_c", 1'b1, 16'h2222, 1'b0, 16'h0014);
        check_eq("br.pc10", PC, 16'h000A);
        check_eq("br.pc11", PC_plus_one, 16'h000B);
        step("br_d", 1'b0, 16'h0000, 1'b0, 16'h0014);
        check_eq("br.pc20", PC, 16'h0014);
        check_eq("br.addr20", imem_addr, 16'h0014);
        check_eq("br.req", 16'(imem_req), 16'h0001);

        // Three wait states, then ack.
        for (int i = 0; i < 3; i++)
            step("wait", 1'b0, 16'hDEAD, 1'b1, 16'(($urandom)));
        step("wait_ack", 1'b1, 16'h3333, 1'b0, 16'h0000);

        // Five stalled cycles with a wandering next-PC.
        for (int i = 0; i < 5; i++)
            step("stall", 1'b0, 16'h0000, 1'b1, 16'($urandom));
        check_eq("stall.ir", IR, 16'h3333);
        check_eq("stall.pc", PC, 16'h0014);

        // Wrap at FFFF.
        step("wrap_a", 1'b0, 16'h0000, 1'b0, 16'hFFFF);
        check_eq("wrap.pc1", PC_plus_one, 16'h0000);
        step("wrap_b", 1'b1, 16'h4444, 1'b0, 16'h0000);
        step("wrap_c", 1'b0, 16'h0000, 1'b0, m_pc + 16'd1);
        check_eq("wrap.pc", PC, 16'h0000);

        // Halt.
        step("halt_a", 1'b1, 16'hFFFF, 1'b0, 16'h0000);
        step("halt_b", 1'b0, 16'h0000, 1'b0, 16'h0055);
        for (int i = 0; i < 4; i++)
            step("halt_hold", 1'b1, 16'($urandom), 1'b0, 16'($urandom));
        check_eq("halt.flag", 16'(halted), 16'h0001);
        check_eq("halt.pc", PC, 16'h0000);

        // Reset mid-fetch at PC=7, then a stray ack during BOOT.
        apply_reset("reset2");
        step("boot2", 1'b0, 16'h0000, 1'b0, 16'h0000);
        step("to7_a", 1'b1, 16'h0100, 1'b0, 16'h0007);
        step("to7_b", 1'b0, 16'h0000, 1'b0, 16'h0007);
        check_eq("mid.pc7", PC, 16'h0007);
        check_eq("mid.req", 16'(imem_req), 16'h0001);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("mid.req0", 16'(imem_req), 16'h0000);
        check_eq("mid.pc0", PC, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("stray", 1'b1, 16'hABCD, 1'b0, 16'h0000);
        check_eq("stray.ir", IR, 16'h0000);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if (($urandom % 97) == 0 || (m_halted && ($urandom % 4) == 0)) begin
                apply_reset("rnd_rst");
            end else begin
                step("rnd",
                     1'(($urandom % 3) == 0),
                     ((($urandom % 12) == 0) ? 16'hFFFF : 16'($urandom)),
                     1'(($urandom % 4) == 0),
                     16'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the 16-bit RISC datapath. It is the consumer end of the next-PC selection path: it supplies `PC_plus_one` to the next-PC mux, latches the mux result `MUX_6_out` as the new PC when the current instruction retires, and drives the instruction-memory fetch handshake. It holds the fetched instruction in `IR` until the datapath consumes it.

## Interface

Parameters:
- `N`, 16, datapath/address width
- `RESET_PC`, 0, PC value loaded at reset
- `HALT_INSTR`, 16'hFFFF, instruction word that stops fetching once retired

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `MUX_6_out`  in  N  next-PC value from the next-PC mux
- `stall`  in  1  datapath not ready to retire the instruction in `IR`
- `imem_ack`  in  1  memory returns data this cycle
- `imem_data`  in  N  instruction word, valid when `imem_ack`=1
- `imem_req`  out  1  fetch request
- `imem_addr`  out  N  fetch address
- `PC`  out  N  current program counter
- `PC_plus_one`  out  N  PC + 1, to the next-PC mux
- `IR`  out  N  instruction register
- `ir_valid`  out  1  `IR` holds an unretired instruction
- `halted`  out  1  halt instruction retired; fetch stopped

## Operation

- One clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: state BOOT, `PC`=RESET_PC, `IR`=0, `ir_valid`=0, `imem_req`=0, `halted`=0. `PC_plus_one`=RESET_PC+1 and `imem_addr`=RESET_PC are derived combinationally from `PC`.
- `PC_plus_one` = (`PC` + 1) mod 2^N, combinational, with no carry out. FFFF wraps to 0000.
- `imem_addr` = `PC` at all times. Memory must only sample it while `imem_req`=1.
- FSM states are BOOT, FETCH, VALID and HALT.
  - BOOT: `imem_req`=0. Goes to FETCH on the next edge, unconditionally.
  - FETCH: `imem_req`=1; `PC` and `IR` are held.
    - On an edge with `imem_ack`=1: `IR`←`imem_data`, go to VALID.
    - Otherwise stay in FETCH. The request stays asserted with a stable address until ack.
    - `stall` is ignored in FETCH.
  - VALID: `imem_req`=0, `ir_valid`=1.
    - On an edge with `stall`=1: hold everything.
    - On an edge with `stall`=0, the instruction retires.
    - If `IR`==HALT_INSTR: `PC` is held, go to HALT.
    - Otherwise: `PC`←`MUX_6_out`, go to FETCH.
  - HALT: `halted`=1, `ir_valid`=0, `imem_req`=0. Only `rst_n` leaves HALT.
- `ir_valid` is 1 only in VALID. `halted` is 1 only in HALT.
- `imem_ack` while `imem_req`=0 is ignored; `IR` is not written.
- `MUX_6_out` is sampled only on a retiring edge (VALID with `stall`=0). It is a don't-care otherwise, and X on it at other times must not propagate.

## Timing

- All outputs except `PC_plus_one` and `imem_addr` are registered.
- Reset to first request: `imem_req` rises 1 cycle after `rst_n` deassertion (the BOOT cycle).
- Zero-wait memory (ack in the first request cycle):
  - `ir_valid` rises the cycle after the request.
  - Steady-state throughput, with no stalls, is one instruction per 2 cycles.
- With k wait cycles (ack k cycles late), `ir_valid` rises k+1 cycles after `imem_req` rises.
- The new `PC` is visible the cycle after a retiring edge. `imem_req` is reasserted in that same cycle, with `imem_addr` equal to the new PC.
- Reset asserted mid-fetch or mid-stall takes effect immediately (async). `imem_req` drops without waiting for ack. A late ack after reset deasserts is ignored in BOOT.

## Test plan

- Reset and boot: hold `rst_n`=0, then release with RESET_PC=0.
  - Expect `PC`=0 and `PC_plus_one`=1.
  - Expect `imem_req`=0 for 1 cycle, then 1 with `imem_addr`=0.
- Sequential fetch: zero-wait memory returning 16'h1234, `MUX_6_out` driven with `PC_plus_one`, `stall`=0.
  - Expect `IR`=1234 with `ir_valid` after 1 cycle.
  - Expect `PC` to step 0→1→2 every 2 cycles.
- Branch: while `IR` is valid, drive `MUX_6_out`=20 (PC=10, PC_plus_one=11).
  - Expect `PC`=20 next cycle, and `imem_addr`=20 with `imem_req`=1.
- Stall and wait states:
  - Ack 3 cycles late: expect `imem_req` held 4 cycles with a stable address.
  - Then hold `stall`=1 for 5 cycles: expect `PC`/`IR` unchanged and `MUX_6_out` changes ignored.
- Wrap and halt:
  - With `PC`=16'hFFFF, expect `PC_plus_one`=0000 and a sequential retire to 0000.
  - Fetch 16'hFFFF and retire it: expect `halted`=1, `imem_req` stuck at 0, and `PC` held.
- Reset mid-fetch: assert `rst_n`=0 while `imem_req`=1 and `PC`=7.
  - Expect `imem_req`=0 and `PC`=0 immediately.
  - A stray ack in BOOT leaves `IR` at 0.
